// File: rtl/fpcvt_arbiter.sv
// -----------------------------------------------------------------------------
// fpcvt_arbiter
//
// Purpose:
//   Shares one FPCVT converter (12-bit two's complement -> sign, 3-bit
//   exponent, 4-bit significand) between two requesters. A round-robin grant
//   picks one operand in IDLE and registers it. The converter runs during
//   CONV, and the result, tagged with the owning requester, is held on a single
//   valid/ready output channel during OUT. Per-requester completion counters
//   wrap modulo 2^CNT_W.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge where
//   valid && ready are both high. A producer holds valid and its payload stable
//   until that edge. reqN_ready depends combinationally on reqN_valid. out_valid
//   is registered and does not depend on out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0_valid/data/ready requester 0 operand channel
//   req1_valid/data/ready requester 1 operand channel
//   out_valid/out_ready   result channel handshake
//   out_id                requester that owns the result
//   out_s, out_e, out_f   converted sign / exponent / significand
//   busy                  high whenever the FSM is not in IDLE
//   cnt0, cnt1            completed (output-handshaked) conversions, wrapping
//   dbg_state             current FSM state (IDLE=0, CONV=1, OUT=2)
// -----------------------------------------------------------------------------

// Combinational FPCVT.
// The magnitude of the operand is normalised so that the significand holds the
// leading one plus the next three bits. The bit just below the significand
// rounds to nearest. A round that overflows the significand renormalises to
// 1000 with the exponent one higher. At the top exponent it saturates to 1111.
// -2048 has no positive counterpart, so it is clamped to magnitude 2047.
module fpcvt (
    input  logic [11:0] d,
    output logic        s,
    output logic [2:0]  e,
    output logic [3:0]  f
);
    logic [11:0] mag;
    logic [2:0]  e_raw;
    logic [12:0] ext;
    logic [3:0]  f_raw;
    logic        rnd;

    always_comb begin
        s     = d[11];
        mag   = d;
        e_raw = 3'd0;
        ext   = 13'd0;
        f_raw = 4'd0;
        rnd   = 1'b0;
        e     = 3'd0;
        f     = 4'd0;

        if (d[11]) begin
            mag = (d == 12'h800) ? 12'h7ff : (~d + 12'd1);
        end

        // Exponent is the position of the leading one minus 3. Values below
        // 16 are stored unnormalised with exponent 0.
        casez (mag[10:4])
            7'b1??????: e_raw = 3'd7;
            7'b01?????: e_raw = 3'd6;
            7'b001????: e_raw = 3'd5;
            7'b0001???: e_raw = 3'd4;
            7'b00001??: e_raw = 3'd3;
            7'b000001?: e_raw = 3'd2;
            7'b0000001: e_raw = 3'd1;
            default:    e_raw = 3'd0;
        endcase

        // A zero is appended below the LSB so the round bit falls out of the
        // same shift. For exponent 0 it is that appended zero.
        ext   = {mag, 1'b0} >> e_raw;
        f_raw = ext[4:1];
        rnd   = ext[0];

        e = e_raw;
        f = f_raw;
        if (rnd) begin
            if (f_raw == 4'hf) begin
                if (e_raw != 3'd7) begin
                    e = e_raw + 3'd1;
                    f = 4'h8;
                end
            end else begin
                f = f_raw + 4'd1;
            end
        end
    end
endmodule

module fpcvt_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [11:0]       req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [11:0]       req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_id,
    output logic              out_s,
    output logic [2:0]        out_e,
    output logic [3:0]        out_f,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t      state_q;
    state_t      state_d;
    logic [11:0] op_reg;
    logic        id_reg;
    logic        last_grant;

    logic        any_valid;
    logic        grant_id;
    logic        accept;
    logic        out_fire;

    logic        cv_s;
    logic [2:0]  cv_e;
    logic [3:0]  cv_f;

    fpcvt u_fpcvt (
        .d (op_reg),
        .s (cv_s),
        .e (cv_e),
        .f (cv_f)
    );

    // Round-robin: a lone valid requester always wins. Under contention the
    // requester that did not win last time is chosen.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        accept     = (state_q == IDLE) & any_valid;
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
        // out_valid is always high in OUT, so the handshake reduces to this.
        out_fire   = (state_q == OUT) & out_ready;
        busy       = (state_q != IDLE);
        dbg_state  = state_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = CONV;
            CONV:    state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= 12'd0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
            out_valid  <= 1'b0;
            out_id     <= 1'b0;
            out_s      <= 1'b0;
            out_e      <= 3'd0;
            out_f      <= 4'd0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            if (accept) begin
                op_reg     <= grant_id ? req1_data : req0_data;
                id_reg     <= grant_id;
                last_grant <= grant_id;
            end

            if (state_q == CONV) begin
                out_s     <= cv_s;
                out_e     <= cv_e;
                out_f     <= cv_f;
                out_id    <= id_reg;
                out_valid <= 1'b1;
            end

            if (out_fire) begin
                out_valid <= 1'b0;
                if (out_id) begin
                    cnt1 <= cnt1 + CNT_ONE;
                end else begin
                    cnt0 <= cnt0 + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpcvt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpcvt_arbiter
//
// Drives two arbiter instances from the same stimulus: the default build
// (CNT_W=8) and a narrow-counter build (CNT_W=2) used to observe wrap-around.
// Expected results come from an arithmetic model of the conversion and the
// round-robin rule. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fpcvt_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [11:0] req0_data;
    logic        req1_valid;
    logic [11:0] req1_data;
    logic        out_ready;

    logic        req0_ready, req1_ready, out_valid, out_id, out_s, busy;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  dbg_state;

    logic        w_req0_ready, w_req1_ready, w_out_valid, w_out_id, w_out_s, w_busy;
    logic [2:0]  w_out_e;
    logic [3:0]  w_out_f;
    logic [1:0]  w_cnt0, w_cnt1;
    logic [1:0]  w_dbg_state;

    fpcvt_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_s(out_s), .out_e(out_e), .out_f(out_f), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1), .dbg_state(dbg_state)
    );

    fpcvt_arbiter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(w_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(w_req1_ready),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_id(w_out_id),
        .out_s(w_out_s), .out_e(w_out_e), .out_f(w_out_f), .busy(w_busy),
        .cnt0(w_cnt0), .cnt1(w_cnt1), .dbg_state(w_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping and model ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    bit         m_last;
    int         m_cnt0;
    int         m_cnt1;
    logic [8:0] exp_q[$];

    // Conversion reference: choose the smallest exponent that brings the
    // magnitude below 16, take the quotient as significand, round half up on
    // the next lower bit, and renormalise or saturate on overflow.
    function automatic logic [7:0] ref_cvt(input logic [11:0] d);
        int v, m, e, f, r;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        e = 0;
        while (e < 7 && (m >> e) >= 16) e++;
        f = m >> e;
        r = (e > 0) ? ((m >> (e - 1)) & 1) : 0;
        f = f + r;
        if (f == 16) begin
            if (e == 7) begin
                f = 15;
            end else begin
                f = 8;
                e = e + 1;
            end
        end
        return {(v < 0) ? 1'b1 : 1'b0, 3'(e), 4'(f)};
    endfunction

    function automatic bit model_grant(input bit v0, input bit v1);
        return (v0 && v1) ? ~m_last : v1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset;
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    // One full transaction from IDLE back to IDLE: accept, convert, handshake.
    task automatic drive_txn(input bit v0, input bit v1,
                             input logic [11:0] d0, input logic [11:0] d1);
        bit g;
        g = model_grant(v0, v1);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        tick();
        m_last = g;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (g) m_cnt1++; else m_cnt0++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_data = 12'd0; req1_data = 12'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_id, out_s, out_e, out_f, req0_ready, req1_ready, busy} !== 13'd0
            || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%b id=%b s=%b e=%b f=%b rdy=%b%b busy=%b cnt=%0d/%0d, required all zero",
                     out_valid, out_id, out_s, out_e, out_f, req0_ready, req1_ready, busy, cnt0, cnt1);
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({out_valid, out_id, out_s, out_e, out_f, req0_ready, req1_ready, busy} !== 13'd0
                || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: got valid=%b id=%b s=%b e=%b f=%b rdy=%b%b busy=%b cnt=%0d/%0d, required all zero",
                         c, out_valid, out_id, out_s, out_e, out_f, req0_ready, req1_ready, busy, cnt0, cnt1);
            end
        end
    endtask

    task automatic test_single;
        logic [11:0] vals[5];
        logic [7:0]  lit[5];
        vals = '{12'd1, 12'd125, 12'd512, 12'h800, 12'h7ff};
        lit  = '{8'b0_000_0001, 8'b0_100_1000, 8'b0_110_1000, 8'b1_111_1111, 8'b0_111_1111};
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_data  = vals[i];
            #1;
            n_cmp++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: got rdy0=%b rdy1=%b, required 1 0", i, req0_ready, req1_ready);
            end
            tick();
            m_last = 1'b0;
            req0_valid = 1'b0;
            req0_data  = 12'($urandom);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_conv[%0d]: got valid=%b busy=%b, required 0 1", i, out_valid, busy);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_id !== 1'b0 || {out_s, out_e, out_f} !== lit[i]) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got valid=%b id=%b sef=%b, required 1 0 %b",
                         i, out_valid, out_id, {out_s, out_e, out_f}, lit[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            m_cnt0++;
            n_cmp++;
            if (out_valid !== 1'b0 || cnt0 !== 8'(m_cnt0)) begin
                n_fail++;
                $display("FAIL single_done[%0d]: got valid=%b cnt0=%0d, required 0 %0d", i, out_valid, cnt0, m_cnt0);
            end
        end
        n_cmp++;
        if (cnt0 !== 8'd5 || cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL single_count: got cnt0=%0d cnt1=%0d, required 5 0", cnt0, cnt1);
        end
    endtask

    task automatic test_contention;
        bit         g;
        logic [8:0] exp;
        apply_reset();
        req0_valid = 1'b1; req0_data = 12'd0;
        req1_valid = 1'b1; req1_data = 12'hE5A;   // -422
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = model_grant(1'b1, 1'b1);
            #1;
            n_cmp++;
            if (req0_ready !== ~g || req1_ready !== g || g !== 1'(i % 2)) begin
                n_fail++;
                $display("FAIL contend_grant[%0d]: got rdy0=%b rdy1=%b, required grant %0d", i, req0_ready, req1_ready, i % 2);
            end
            exp_q.push_back({g, ref_cvt(g ? req1_data : req0_data)});
            m_last = g;
            tick();
            n_cmp++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL contend_conv[%0d]: got rdy=%b%b valid=%b busy=%b, required 00 0 1",
                         i, req0_ready, req1_ready, out_valid, busy);
            end
            tick();
            exp = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {out_id, out_s, out_e, out_f} !== exp
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL contend_result[%0d]: got valid=%b id_sef=%b rdy=%b%b, required 1 %b 00",
                         i, out_valid, {out_id, out_s, out_e, out_f}, req0_ready, req1_ready, exp);
            end
            tick();
            if (exp[8]) m_cnt1++; else m_cnt0++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        n_cmp++;
        if (cnt0 !== 8'd2 || cnt1 !== 8'd2 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_count: got cnt0=%0d cnt1=%0d valid=%b, required 2 2 0", cnt0, cnt1, out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] exp;
        req0_valid = 1'b1; req0_data = 12'($urandom);
        req1_valid = 1'b1; req1_data = 12'($urandom);
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_grant0: got rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        exp = {1'b0, ref_cvt(req0_data)};
        m_last = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || {out_id, out_s, out_e, out_f} !== exp
                || busy !== 1'b1 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got valid=%b id_sef=%b busy=%b rdy1=%b, required 1 %b 1 0",
                         c, out_valid, {out_id, out_s, out_e, out_f}, busy, req1_ready, exp);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_cnt0++;
        n_cmp++;
        if (out_valid !== 1'b0 || req1_ready !== 1'b1 || cnt0 !== 8'(m_cnt0)) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b rdy1=%b cnt0=%0d, required 0 1 %0d",
                     out_valid, req1_ready, cnt0, m_cnt0);
        end
        exp = {1'b1, ref_cvt(req1_data)};
        m_last = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_id, out_s, out_e, out_f} !== exp) begin
            n_fail++;
            $display("FAIL bp_req1_result: got valid=%b id_sef=%b, required 1 %b",
                     out_valid, {out_id, out_s, out_e, out_f}, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_cnt1++;
        n_cmp++;
        if (cnt1 !== 8'(m_cnt1) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got cnt1=%0d busy=%b, required %0d 0", cnt1, busy, m_cnt1);
        end
    endtask

    task automatic test_random;
        bit         v0, v1, g, pre;
        int         stall;
        logic [8:0] exp;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            req0_valid = v0; req0_data = 12'($urandom);
            req1_valid = v1; req1_data = 12'($urandom);
            #1;
            if (!v0 && !v1) begin
                n_cmp++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle[%0d]: got rdy=%b%b busy=%b, required 00 0", i, req0_ready, req1_ready, busy);
                end
                tick();
                continue;
            end
            g = model_grant(v0, v1);
            n_cmp++;
            if (req0_ready !== ~g || req1_ready !== g) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got rdy0=%b rdy1=%b, required grant %0d (v=%b%b)",
                         i, req0_ready, req1_ready, g, v0, v1);
            end
            exp_q.push_back({g, ref_cvt(g ? req1_data : req0_data)});
            m_last = g;
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            pre = 1'($urandom_range(0, 1));
            out_ready = pre;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_conv[%0d]: got valid=%b busy=%b, required 0 1", i, out_valid, busy);
            end
            tick();
            exp = exp_q.pop_front();
            stall = pre ? 0 : $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {out_id, out_s, out_e, out_f} !== exp) begin
                    n_fail++;
                    $display("FAIL rand_result[%0d.%0d]: got valid=%b id_sef=%b, required 1 %b",
                             i, s, out_valid, {out_id, out_s, out_e, out_f}, exp);
                end
                if (s < stall) tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (exp[8]) m_cnt1++; else m_cnt0++;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || cnt0 !== 8'(m_cnt0) || cnt1 !== 8'(m_cnt1)) begin
                n_fail++;
                $display("FAIL rand_done[%0d]: got valid=%b busy=%b cnt=%0d/%0d, required 0 0 %0d/%0d",
                         i, out_valid, busy, cnt0, cnt1, m_cnt0, m_cnt1);
            end
        end
    endtask

    task automatic test_wrap;
        logic [1:0] seq[5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_txn(1'b0, 1'b1, 12'd0, 12'($urandom));
            n_cmp++;
            if (w_cnt1 !== seq[i] || w_cnt0 !== 2'd0 || cnt1 !== 8'(m_cnt1)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got w_cnt1=%0d w_cnt0=%0d cnt1=%0d, required %0d 0 %0d",
                         i, w_cnt1, w_cnt0, cnt1, seq[i], m_cnt1);
            end
        end
    endtask

    task automatic test_midreset;
        logic [8:0] exp;
        apply_reset();
        drive_txn(1'b0, 1'b1, 12'd0, 12'd77);
        req0_valid = 1'b1; req0_data = 12'd300;
        tick();
        req0_valid = 1'b0;
        m_last = 1'b0;
        // now in the conversion cycle
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || cnt1 !== 8'd0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got busy=%b valid=%b cnt1=%0d state=%0d, required 0 0 0 0",
                     busy, out_valid, cnt1, dbg_state);
        end
        #1 rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_discard: got valid=%b busy=%b cnt=%0d/%0d, required 0 0 0/0",
                     out_valid, busy, cnt0, cnt1);
        end
        req0_valid = 1'b1; req0_data = 12'hF00;
        req1_valid = 1'b1; req1_data = 12'd5;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_grant: got rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        exp = {1'b0, ref_cvt(req0_data)};
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_id, out_s, out_e, out_f} !== exp) begin
            n_fail++;
            $display("FAIL midrst_result: got valid=%b id_sef=%b, required 1 %b",
                     out_valid, {out_id, out_s, out_e, out_f}, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_count: got cnt0=%0d cnt1=%0d valid=%b, required 1 0 0", cnt0, cnt1, out_valid);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_random();
        test_wrap();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fpcvt_arbiter.md
# fpcvt_arbiter

Round-robin scheduler that shares one FPCVT converter (12-bit two's-complement to sign/3-bit exponent/4-bit significand) between two requesters. Each requester has a valid/ready channel. The block registers the granted operand, drives it into an internally instantiated FPCVT, captures the result with the requester ID, and presents it on a single valid/ready output channel. Per-requester completion counters support debug and statistics.

## Interface
- CNT_W, 8, width of per-requester completion counters; counters wrap.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operand.
- req0_data  in  12  requester 0 operand, two's complement.
- req0_ready  out  1  requester 0 operand accepted this cycle.
- req1_valid  in  1  requester 1 has an operand.
- req1_data  in  12  requester 1 operand, two's complement.
- req1_ready  out  1  requester 1 operand accepted this cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_id  out  1  requester that owns the result.
- out_s  out  1  FPCVT S.
- out_e  out  3  FPCVT E.
- out_f  out  4  FPCVT F.
- busy  out  1  high in every state except IDLE.
- cnt0, cnt1  out  CNT_W  completed (output-handshaked) conversions per requester.

## Operation
- FSM states: IDLE, CONV, OUT. Reset state is IDLE.
- IDLE: if any reqN_valid is high, grant one requester. reqN_ready is driven combinationally and is high only for the granted requester, only in IDLE. On the clock edge, latch reqN_data into op_reg, latch N into id_reg, set last_grant=N, and go to CONV. If no requester is valid, stay in IDLE.
- Arbitration: with one valid requester, grant it. With both valid, grant the requester not equal to last_grant. last_grant resets to 1, so requester 0 wins the first contention.
- CONV: op_reg drives FPCVT.D. On the edge, capture S/E/F into out_s/out_e/out_f, set out_id=id_reg and out_valid=1, and go to OUT.
- OUT: out_valid stays high and out_* stay stable until out_valid&out_ready on a clock edge. On that edge:
  - clear out_valid;
  - increment cnt[out_id], modulo 2^CNT_W;
  - go to IDLE.
- No request is accepted in CONV or OUT. reqN_ready stays 0 there regardless of reqN_valid.
- Requesters must hold valid and data stable until ready. A requester that deasserts valid before grant is never serviced for that operand.
- Conversion values are exactly FPCVT's, including its rounding and saturation: 2047 and -2048 both give E=7, F=1111.

## Timing
- Reset values:
  - out_valid=0, out_id=0, out_s=0, out_e=0, out_f=0;
  - req0_ready=0, req1_ready=0, busy=0;
  - cnt0=0, cnt1=0, last_grant=1, op_reg=0, state IDLE.
- Latency: with operand accepted at edge k, out_valid is high from edge k+1.
- Minimum period is 3 cycles per conversion: accept at edge k, result at k+1, output handshake at k+2, next accept at k+3.
- out_ready already high when out_valid rises means the handshake happens at the following edge.
- Simultaneous events:
  - Both requesters valid in IDLE: exactly one ready asserts.
  - Ready never asserts in the same cycle as an output handshake.
- Counter wrap: cnt at 2^CNT_W-1 plus one completion gives 0, with no flag.
- Reset asserted mid-operation (CONV or OUT): all state clears immediately, independent of clk. Any in-flight result is discarded and not counted. After rst_n deasserts, the first grant follows normal IDLE rules.

## Test plan
- Reset and idle: hold rst_n=0, then release with no requests. Outputs stay at reset values and busy=0 for 10 cycles.
- Single requester, multiple values:
  - req0_data 1 → out_id=0, S=0, E=000, F=0001;
  - 125 → E=100, F=1000;
  - 512 → E=110, F=1000;
  - -2048 → S=1, E=111, F=1111;
  - 2047 → S=0, E=111, F=1111.
  - Each result appears one edge after accept. cnt0=5 at the end.
- Contention: both valid continuously with distinct operands (0 and -422), out_ready=1. Grants alternate 0,1,0,1. out_id alternates accordingly. New accepts come every 3 cycles.
- Backpressure: out_ready=0 for 7 cycles after out_valid rises.
  - out_* stay stable and busy=1.
  - req1_ready stays 0 although req1_valid=1.
  - After out_ready rises, the handshake happens, then req1 is granted in the next cycle.
- Counter wrap: with CNT_W=2, five completions on requester 1 give cnt1 sequence 1,2,3,0,1. cnt0 stays 0.
- Mid-operation reset: pulse rst_n low in the CONV cycle. out_valid stays 0 and the count is unchanged. A fresh request after release completes normally.
